// File: rtl/npc_pc_if.sv
// Fetch-side next-PC bundle: D-stage transfer info and CP0 redirects in,
// fetch address and its status flags out.
interface npc_pc_if;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [5:0]  npc_op;
  logic        br_cond;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] d_rs;
  logic [31:0] f_pc;
  logic        f_adel;
  logic        f_bd;
  logic        f_redirect;
  logic        d_flush;

  modport master (
    output stall, req, eret, epc, npc_op, br_cond, d_pc, d_imm16, d_index26, d_rs,
    input  f_pc, f_adel, f_bd, f_redirect, d_flush
  );

  modport slave (
    input  stall, req, eret, epc, npc_op, br_cond, d_pc, d_imm16, d_index26, d_rs,
    output f_pc, f_adel, f_bd, f_redirect, d_flush
  );
endinterface

// File: rtl/npc_pc_unit.sv
// F-stage PC register and next-PC selection for a delay-slot MIPS-style pipeline,
// with CP0 exception entry / ERET redirection and fetch address checking.
module npc_pc_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic       clk,
  input  logic       reset,
  npc_pc_if.slave    bus
);

  localparam logic [5:0] OP_BEQ = 6'b001000;
  localparam logic [5:0] OP_BNE = 6'b001001;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_JR  = 6'b000100;

  logic [31:0] pc_q;
  logic        redirect_q;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        is_branch;
  logic        is_jump;
  logic        is_jr;
  logic        redirect;

  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_tgt    = bus.d_pc + 32'd4 + {{14{bus.d_imm16[15]}}, bus.d_imm16, 2'b00};
    j_tgt     = {bus.d_pc[31:28], bus.d_index26, 2'b00};
    is_branch = (bus.npc_op == OP_BEQ) || (bus.npc_op == OP_BNE);
    is_jump   = (bus.npc_op == OP_J) || (bus.npc_op == OP_JAL);
    is_jr     = (bus.npc_op == OP_JR);
    redirect  = bus.req || bus.eret;
  end

  // CP0 redirects outrank a stall; unknown opcodes fall through to sequential.
  always_comb begin
    pc_next = pc_plus4;
    if (bus.req)
      pc_next = EXC_ENTRY;
    else if (bus.eret)
      pc_next = bus.epc;
    else if (bus.stall)
      pc_next = pc_q;
    else if (is_branch)
      pc_next = bus.br_cond ? br_tgt : pc_plus4;
    else if (is_jump)
      pc_next = j_tgt;
    else if (is_jr)
      pc_next = bus.d_rs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_next;
      redirect_q <= redirect;
    end
  end

  assign bus.f_pc       = pc_q;
  assign bus.f_redirect = redirect_q;
  assign bus.d_flush    = redirect;
  assign bus.f_bd       = (is_branch || is_jump || is_jr) && !redirect;
  assign bus.f_adel     = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed, table-driven checks of npc_pc_unit sequencing, targets and CP0 redirects.
module tb_npc_pc_unit;

  logic clk;
  logic reset;
  npc_pc_if bus ();

  npc_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] SEQ = 6'b000000;
  localparam logic [5:0] BEQ = 6'b001000;
  localparam logic [5:0] BNE = 6'b001001;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011;
  localparam logic [5:0] JR  = 6'b000100;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [5:0]  op;
    logic        br;
    logic [31:0] dpc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic        exp_flush;
    logic        exp_bd;
    logic [31:0] exp_pc;
    logic        exp_redirect;
    logic        exp_adel;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(string name, logic rst, logic stall, logic req, logic eret,
                              logic [31:0] epc, logic [5:0] op, logic br, logic [31:0] dpc,
                              logic [15:0] imm, logic [25:0] idx, logic [31:0] rs,
                              logic exp_flush, logic exp_bd, logic [31:0] exp_pc,
                              logic exp_redirect, logic exp_adel);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.req = req; v.eret = eret;
    v.epc = epc; v.op = op; v.br = br; v.dpc = dpc; v.imm = imm; v.idx = idx; v.rs = rs;
    v.exp_flush = exp_flush; v.exp_bd = exp_bd; v.exp_pc = exp_pc;
    v.exp_redirect = exp_redirect; v.exp_adel = exp_adel;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one vector, check the combinational flags before the edge, then the registered state after it.
  task automatic apply_stimulus(input vec_t v);
    reset         = v.rst;
    bus.stall     = v.stall;
    bus.req       = v.req;
    bus.eret      = v.eret;
    bus.epc       = v.epc;
    bus.npc_op    = v.op;
    bus.br_cond   = v.br;
    bus.d_pc      = v.dpc;
    bus.d_imm16   = v.imm;
    bus.d_index26 = v.idx;
    bus.d_rs      = v.rs;
    #1;
    check_output({v.name, " d_flush"}, {31'd0, bus.d_flush}, {31'd0, v.exp_flush});
    check_output({v.name, " f_bd"},    {31'd0, bus.f_bd},    {31'd0, v.exp_bd});
    @(posedge clk);
    #1;
    check_output({v.name, " f_pc"},       bus.f_pc,                {v.exp_pc});
    check_output({v.name, " f_redirect"}, {31'd0, bus.f_redirect}, {31'd0, v.exp_redirect});
    check_output({v.name, " f_adel"},     {31'd0, bus.f_adel},     {31'd0, v.exp_adel});
  endtask

  initial begin
    // Straight-line flow, targets and address-range boundaries.
    //                 name          rst st rq er epc  op   br dpc          imm       idx         rs           fl bd pc           rd ad
    vecs.push_back(mk("reset0",      1, 0, 0, 0, 0,   SEQ, 0, 0,           16'h0,    26'h0,      0,           0, 0, 32'h3000,     0, 0));
    vecs.push_back(mk("reset1",      1, 0, 0, 0, 0,   SEQ, 0, 0,           16'h0,    26'h0,      0,           0, 0, 32'h3000,     0, 0));
    vecs.push_back(mk("seq0",        0, 0, 0, 0, 0,   SEQ, 0, 0,           16'h0,    26'h0,      0,           0, 0, 32'h3004,     0, 0));
    vecs.push_back(mk("seq1",        0, 0, 0, 0, 0,   SEQ, 0, 0,           16'h0,    26'h0,      0,           0, 0, 32'h3008,     0, 0));
    vecs.push_back(mk("beq_taken",   0, 0, 0, 0, 0,   BEQ, 1, 32'h3008,    16'hFFFE, 26'h0,      0,           0, 1, 32'h3004,     0, 0));
    vecs.push_back(mk("beq_not",     0, 0, 0, 0, 0,   BEQ, 0, 32'h3008,    16'hFFFE, 26'h0,      0,           0, 1, 32'h3008,     0, 0));
    vecs.push_back(mk("jal",         0, 0, 0, 0, 0,   JAL, 0, 32'h3010,    16'h0,    26'hC40,    0,           0, 1, 32'h3100,     0, 0));
    vecs.push_back(mk("jr_misalign", 0, 0, 0, 0, 0,   JR,  0, 0,           16'h0,    26'h0,      32'h3002,    0, 1, 32'h3002,     0, 1));
    vecs.push_back(mk("seq_misal",   0, 0, 0, 0, 0,   SEQ, 0, 0,           16'h0,    26'h0,      0,           0, 0, 32'h3006,     0, 1));
    vecs.push_back(mk("bne_fwd",     0, 0, 0, 0, 0,   BNE, 1, 32'h3100,    16'h0010, 26'h0,      0,           0, 1, 32'h3144,     0, 0));
    vecs.push_back(mk("op_unknown",  0, 0, 0, 0, 0,   6'h3F, 1, 32'h3100,  16'h0100, 26'h3FF,    32'h5000,    0, 0, 32'h3148,     0, 0));
    vecs.push_back(mk("j_above_hi",  0, 0, 0, 0, 0,   J,   0, 32'h3200,    16'h0,    26'h1C00,   0,           0, 1, 32'h7000,     0, 1));
    vecs.push_back(mk("j_at_hi",     0, 0, 0, 0, 0,   J,   0, 32'h3200,    16'h0,    26'h1BFF,   0,           0, 1, 32'h6FFC,     0, 0));
    vecs.push_back(mk("seq_past_hi", 0, 0, 0, 0, 0,   SEQ, 0, 0,           16'h0,    26'h0,      0,           0, 0, 32'h7000,     0, 1));
    vecs.push_back(mk("j_below_lo",  0, 0, 0, 0, 0,   J,   0, 32'h3200,    16'h0,    26'hBFF,    0,           0, 1, 32'h2FFC,     0, 1));
    vecs.push_back(mk("j_at_lo",     0, 0, 0, 0, 0,   J,   0, 32'h3200,    16'h0,    26'hC00,    0,           0, 1, 32'h3000,     0, 0));
    vecs.push_back(mk("j_hi_nibble", 0, 0, 0, 0, 0,   J,   0, 32'hA000_0000, 16'h0,  26'hC00,    0,           0, 1, 32'hA000_3000, 0, 1));
    vecs.push_back(mk("jr_back",     0, 0, 0, 0, 0,   JR,  0, 0,           16'h0,    26'h0,      32'h3000,    0, 1, 32'h3000,     0, 0));

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Stalled jump held three edges, then released.
    for (int k = 0; k < 3; k++)
      apply_stimulus(mk("stall_hold", 0, 1, 0, 0, 0, J, 0, 32'h3000, 16'h0, 26'hC40, 0,
                        0, 1, 32'h3000, 0, 0));
    apply_stimulus(mk("stall_release", 0, 0, 0, 0, 0, J, 0, 32'h3000, 16'h0, 26'hC40, 0,
                      0, 1, 32'h3100, 0, 0));

    // Exception request beats a stall and a taken branch; redirect lasts one edge.
    apply_stimulus(mk("req_stall", 0, 1, 1, 0, 0, BNE, 1, 32'h3100, 16'h0010, 26'h0, 0,
                      1, 0, 32'h4180, 1, 0));
    apply_stimulus(mk("after_req", 0, 0, 0, 0, 0, SEQ, 0, 0, 16'h0, 26'h0, 0,
                      0, 0, 32'h4184, 0, 0));

    // req and eret together, eret alone, stalled edge clears redirect, reset mid-stall.
    apply_stimulus(mk("req_eret", 0, 0, 1, 1, 32'h3020, SEQ, 0, 0, 16'h0, 26'h0, 0,
                      1, 0, 32'h4180, 1, 0));
    apply_stimulus(mk("eret", 0, 0, 0, 1, 32'h3020, JR, 0, 0, 16'h0, 26'h0, 32'h5000,
                      1, 0, 32'h3020, 1, 0));
    apply_stimulus(mk("stall_clr", 0, 1, 0, 0, 0, SEQ, 0, 0, 16'h0, 26'h0, 0,
                      0, 0, 32'h3020, 0, 0));
    apply_stimulus(mk("eret_stall", 0, 1, 0, 1, 32'h3040, SEQ, 0, 0, 16'h0, 26'h0, 0,
                      1, 0, 32'h3040, 1, 0));
    apply_stimulus(mk("reset_stall", 1, 1, 1, 0, 0, BEQ, 1, 32'h3040, 16'h0040, 26'h0, 0,
                      1, 0, 32'h3000, 0, 0));
    apply_stimulus(mk("post_reset", 0, 0, 0, 0, 0, SEQ, 0, 0, 16'h0, 26'h0, 0,
                      0, 0, 32'h3004, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- Fetch-side consumer of the D-stage branch comparator flag.
- Holds the F-stage PC register and computes the next PC from the decoded control-transfer type, the comparator condition, the jump operands, the exception request and ERET.
- Flags fetch address errors and delay-slot membership for the CP0 path.
- Sits between the D-stage decoder/comparator and the instruction memory address port.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; hold PC.
- req  in  1  exception/interrupt request from CP0 (M stage).
- eret  in  1  ERET committing in M stage.
- epc  in  32  return address from CP0.
- npc_op  in  6  D-stage transfer type: 000000 SEQ, 001000 BEQ, 001001 BNE, 000010 J, 000011 JAL, 000100 JR; other codes are treated as SEQ.
- br_cond  in  1  comparator result for the D-stage branch; already type-qualified, 1 = taken.
- d_pc  in  32  PC of the D-stage instruction.
- d_imm16  in  16  branch offset.
- d_index26  in  26  J/JAL instruction index.
- d_rs  in  32  forwarded rs value for JR.
- f_pc  out  32  current fetch address (registered).
- f_adel  out  1  fetch address error for the instruction at f_pc.
- f_bd  out  1  instruction at f_pc is a delay slot.
- f_redirect  out  1  f_pc was loaded by exception entry or ERET this cycle (registered).
- d_flush  out  1  kill the instruction entering D next edge.

Behaviour:
- Reset, synchronous, dominates all inputs:
  - f_pc = PC_RESET, f_redirect = 0.
  - Combinational outputs then follow from f_pc and the current inputs.
- Targets, all 32-bit, wrap modulo 2^32:
  - br_tgt = d_pc + 4 + (sign_ext(d_imm16) << 2).
  - j_tgt = {d_pc[31:28], d_index26, 2'b00}.
  - jr_tgt = d_rs, unmodified; misalignment is reported, never corrected.
- Next-PC priority, evaluated each edge (first match wins):
  1. reset -> PC_RESET.
  2. req -> EXC_ENTRY, even while stall = 1.
  3. eret -> epc, even while stall = 1.
  4. stall -> hold f_pc.
  5. BEQ/BNE with br_cond = 1 -> br_tgt.
  6. BEQ/BNE with br_cond = 0 -> f_pc + 4.
  7. J/JAL -> j_tgt.
  8. JR -> jr_tgt.
  9. otherwise -> f_pc + 4.
- Latency: one edge from inputs to f_pc. No internal pipelining.
- f_redirect: set to 1 on an edge taken via rule 2 or 3; cleared on any other edge, including a stalled one.
- d_flush (combinational):
  - 1 when req or eret is asserted, so the wrong-path fetch is killed.
  - 0 otherwise. Branches have a delay slot and never flush.
- f_bd (combinational): 1 when npc_op is not SEQ and req = 0 and eret = 0; 0 otherwise.
- f_adel (combinational): 1 when f_pc[1:0] != 0, or f_pc < IM_LO, or f_pc > IM_HI (unsigned compare).
- f_adel does not alter sequencing; CP0 raises req and rule 2 redirects.
- Simultaneous events:
  - req and eret both asserted -> req wins.
  - Branch or jump in D during stall -> ignored this edge and re-evaluated next edge; D holds its instruction.
- Reset asserted mid-stall or mid-redirect clears everything on that edge.

Test Plan:
- Reset asserted two cycles, then sequential flow -> f_pc = 0x3000, then 0x3004, 0x3008; f_redirect = 0, f_adel = 0.
- npc_op = BEQ, br_cond = 1, d_pc = 0x3008, imm = 0xFFFE -> next f_pc = 0x3004, f_bd = 1. Repeat with br_cond = 0 -> f_pc + 4.
- npc_op = JAL, d_pc = 0x3010, index = 0x0000C40 -> f_pc = 0x3100. JR with d_rs = 0x3002 -> f_pc = 0x3002, f_adel = 1.
- stall = 1 with npc_op = J held three cycles -> f_pc unchanged. stall drops -> f_pc = j_tgt.
- req = 1 with stall = 1 and BNE taken -> f_pc = 0x4180, f_redirect = 1 for one cycle, d_flush = 1 in the req cycle, f_bd = 0.
- eret = 1, epc = 0x3020, concurrent req = 1 -> f_pc = 0x4180. Next, eret alone -> f_pc = 0x3020. Then reset during stall -> f_pc = 0x3000.
